// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined main memory between the I-cache fill,
// the D-cache fill and D-cache write-through stores. Fills issue a whole
// block of back-to-back word reads and steer the returning words to the
// owner; returns are counted, not timed, so memory latency may vary.
module mem_arbiter #(
  parameter int WORDS   = 8,
  parameter int MEM_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ic_miss,
  input  logic [15:0] ic_addr,
  input  logic        dc_miss,
  input  logic [15:0] dc_addr,
  input  logic        dc_wr,
  input  logic [15:0] dc_wr_addr,
  input  logic [15:0] dc_wr_data,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_data_valid,
  input  logic [15:0] mem_rdata,
  output logic        ic_data_valid,
  output logic        dc_data_valid,
  output logic [2:0]  fill_word,
  output logic [15:0] fill_data,
  output logic        ic_fill_done,
  output logic        dc_fill_done,
  output logic        dc_wr_ack,
  output logic        wait_icache
);

  // Reject block sizes the 3-bit word index and 4-bit counters cannot cover.
  if (WORDS < 2 || WORDS > 8 || MEM_LAT < 1) begin : g_param_check
    $error("mem_arbiter: WORDS must be 2..8 and MEM_LAT at least 1");
  end

  // Block base clears the byte offset of a whole block (2 bytes per word).
  localparam logic [15:0] BLK_MASK = ~(16'(2 * WORDS) - 16'd1);
  localparam logic [3:0]  WORDS_C  = 4'(WORDS);
  localparam logic [3:0]  LAST_IDX = 4'(WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_IFILL = 2'd1,
    ST_DFILL = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [3:0]  iss_r, iss_nxt_s;
  logic [3:0]  ret_r, ret_nxt_s;
  logic [15:0] base_r, base_nxt_s;
  logic        in_fill_s, issue_s, accept_s, last_s;

  // Decode what the current fill is doing this cycle.
  always_comb begin
    in_fill_s = (state_r == ST_IFILL) || (state_r == ST_DFILL);
    issue_s   = in_fill_s && (iss_r < WORDS_C);
    accept_s  = in_fill_s && mem_data_valid && (ret_r < WORDS_C);
    last_s    = accept_s && (ret_r == LAST_IDX);
  end

  // Next state, counters and latched block base.
  always_comb begin
    state_nxt_s = state_r;
    iss_nxt_s   = iss_r;
    ret_nxt_s   = ret_r;
    base_nxt_s  = base_r;
    case (state_r)
      ST_IDLE: begin
        iss_nxt_s = 4'd0;
        ret_nxt_s = 4'd0;
        if (ic_miss) begin
          state_nxt_s = ST_IFILL;
          base_nxt_s  = ic_addr & BLK_MASK;
        end else if (dc_wr) begin
          state_nxt_s = ST_WRITE;
        end else if (dc_miss) begin
          state_nxt_s = ST_DFILL;
          base_nxt_s  = dc_addr & BLK_MASK;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_IFILL, ST_DFILL: begin
        if (last_s) begin
          state_nxt_s = ST_IDLE;
          iss_nxt_s   = 4'd0;
          ret_nxt_s   = 4'd0;
        end else begin
          if (issue_s) begin
            iss_nxt_s = iss_r + 4'd1;
          end else begin
            iss_nxt_s = iss_r;
          end
          if (accept_s) begin
            ret_nxt_s = ret_r + 4'd1;
          end else begin
            ret_nxt_s = ret_r;
          end
        end
      end
      ST_WRITE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        iss_nxt_s   = 4'd0;
        ret_nxt_s   = 4'd0;
      end
    endcase
  end

  // State, counter and base registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      iss_r   <= 4'd0;
      ret_r   <= 4'd0;
      base_r  <= 16'd0;
    end else begin
      state_r <= state_nxt_s;
      iss_r   <= iss_nxt_s;
      ret_r   <= ret_nxt_s;
      base_r  <= base_nxt_s;
    end
  end

  // Memory strobes and return steering, decoded from registered state.
  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 16'd0;
    mem_wdata = 16'd0;
    dc_wr_ack = 1'b0;
    if (state_r == ST_WRITE) begin
      mem_en    = 1'b1;
      mem_wr    = 1'b1;
      mem_addr  = dc_wr_addr;
      mem_wdata = dc_wr_data;
      dc_wr_ack = 1'b1;
    end else if (issue_s) begin
      mem_en   = 1'b1;
      mem_addr = base_r | ({12'd0, iss_r} << 1);
    end else begin
      mem_en = 1'b0;
    end
    ic_data_valid = accept_s && (state_r == ST_IFILL);
    dc_data_valid = accept_s && (state_r == ST_DFILL);
    ic_fill_done  = last_s && (state_r == ST_IFILL);
    dc_fill_done  = last_s && (state_r == ST_DFILL);
    fill_word     = ret_r[2:0];
    fill_data     = mem_rdata;
    wait_icache   = (state_r == ST_IFILL) || ((state_r == ST_IDLE) && ic_miss);
  end

endmodule
